// File: rtl/imem_resp.sv
// imem_resp: fixed-latency instruction memory responder with loader write port.
// Optional feature: define IMEM_RESP_ERR_EN to report out-of-range reads on
// ram_err_o (with zero data); otherwise the read index wraps modulo DEPTH.
module imem_resp #(
    parameter int          LATENCY   = 2,
    parameter int          DEPTH     = 1024,
    parameter logic [63:0] BASE_ADDR = 64'h8000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ram_cen_i,
    input  logic [63:0] ram_addr_i,
    input  logic [2:0]  ram_size_i,
    output logic [63:0] ram_data_o,
    output logic        ram_valid_o,
    output logic        ram_err_o,
    output logic        busy_o,
    input  logic        ld_wen_i,
    input  logic [63:0] ld_addr_i,
    input  logic [63:0] ld_wdata_i
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t        r_state, w_next;
    logic [3:0]    r_cnt, w_cnt_next;
    logic [IW-1:0] r_idx;
    logic [IW-1:0] w_req_idx, w_ld_idx, w_rd_idx;
    logic          w_ld_oor;
    logic [63:0]   r_mem [DEPTH];
    logic [63:0]   r_data;
    logic          r_valid;
    logic          w_unused_size;

    // Only doubleword reads exist, so the size field carries no information.
    assign w_unused_size = ^ram_size_i;

    function automatic logic f_oor(input logic [63:0] a);
        logic [63:0] dw;
        dw = (a - BASE_ADDR) >> 3;
        return (a < BASE_ADDR) || (dw >= 64'(DEPTH));
    endfunction

    function automatic logic [IW-1:0] f_idx(input logic [63:0] a);
        logic [63:0] dw;
        dw = (a - BASE_ADDR) >> 3;
        return IW'(dw % 64'(DEPTH));
    endfunction

    assign w_req_idx = f_idx(ram_addr_i);
    assign w_ld_idx  = f_idx(ld_addr_i);
    assign w_ld_oor  = f_oor(ld_addr_i);

    // A strobe that lands directly in RESP (LATENCY=1) reads the new index.
    assign w_rd_idx  = ram_cen_i ? w_req_idx : r_idx;

    // Next-state and counter logic; any strobe restarts the request.
    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        case (r_state)
            S_IDLE: ;
            S_WAIT: begin
                if (r_cnt <= 4'd1) begin
                    w_next     = S_RESP;
                    w_cnt_next = '0;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (ram_cen_i) begin
            if (LATENCY == 1) begin
                w_next     = S_RESP;
                w_cnt_next = '0;
            end else begin
                w_next     = S_WAIT;
                w_cnt_next = 4'(LATENCY - 1);
            end
        end
    end

    // State, counter and captured request index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            if (ram_cen_i) r_idx <= w_req_idx;
        end
    end

`ifdef IMEM_RESP_ERR_EN
    logic r_oor, r_err, w_req_oor, w_rd_oor;

    assign w_req_oor = f_oor(ram_addr_i);
    assign w_rd_oor  = ram_cen_i ? w_req_oor : r_oor;

    // Response registers; an out-of-range read answers with zero data and err.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_oor   <= 1'b0;
            r_err   <= 1'b0;
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            if (ram_cen_i) r_oor <= w_req_oor;
            r_valid <= (w_next == S_RESP);
            r_err   <= (w_next == S_RESP) && w_rd_oor;
            if (w_next == S_RESP) r_data <= w_rd_oor ? '0 : r_mem[w_rd_idx];
        end
    end

    assign ram_err_o = r_err;
`else
    // Response registers; data is sampled on entry to RESP and held afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            r_valid <= (w_next == S_RESP);
            if (w_next == S_RESP) r_data <= r_mem[w_rd_idx];
        end
    end

    assign ram_err_o = 1'b0;
`endif

    // Loader write port; the array is never reset and out-of-range writes are dropped.
    // Response data is captured one edge before RESP, so a same-index write
    // during RESP lands after the read (read-before-write).
    always_ff @(posedge clk) begin
        if (ld_wen_i && !w_ld_oor) r_mem[w_ld_idx] <= ld_wdata_i;
    end

    assign ram_data_o  = r_data;
    assign ram_valid_o = r_valid;
    assign busy_o      = (r_state != S_IDLE);

endmodule
